// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register and HALT freeze for a single-issue RISC-V front end.
module fetch_stage #(
  parameter int PC_W = 9,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter logic [6:0] HALT_OPC = 7'b1001100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_instr,
  output logic [6:0]        id_opcode,
  output logic              id_valid,
  output logic              halted
);
  logic [PC_W-1:0] pc;
  logic is_halt;
  assign imem_addr = pc;
  assign id_opcode = id_instr[6:0];
  assign is_halt = imem_rdata[6:0] == HALT_OPC;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      id_pc <= '0;
      id_instr <= NOP_INST;
      id_valid <= 1'b0;
      halted <= 1'b0;
    end else if (redirect) begin
      pc <= {redirect_pc[PC_W-1:2], 2'b00};
      id_pc <= pc;
      id_instr <= NOP_INST;
      id_valid <= 1'b0;
      halted <= 1'b0;
    end else if (halted) begin
      // the captured HALT drains once, then bubbles follow
      if (!stall) begin
        id_pc <= pc;
        id_instr <= NOP_INST;
        id_valid <= 1'b0;
      end
    end else if (!stall) begin
      id_pc <= pc;
      id_instr <= imem_rdata;
      id_valid <= 1'b1;
      halted <= is_halt;
      pc <= is_halt ? pc : pc + PC_W'(4);
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a behavioural fetch model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [6:0] HALT = 7'b1001100;
  logic clk = 1'b0;
  logic reset, stall, redirect;
  logic [8:0] redirect_pc, imem_addr, id_pc;
  logic [31:0] imem_rdata, id_instr;
  logic [6:0] id_opcode;
  logic id_valid, halted;
  logic [31:0] mem [128];
  int tests = 0, fails = 0;
  int m_pc, m_ipc;
  logic [31:0] m_ins;
  bit m_v, m_h;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode),
    .id_valid(id_valid), .halted(halted)
  );

  assign imem_rdata = mem[imem_addr[8:2]];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_inst(input bit allow_halt);
    logic [31:0] w;
    w = $urandom;
    if (w[6:0] == HALT) w[6:0] = 7'h33;
    if (allow_halt && $urandom_range(15) == 0) w[6:0] = HALT;
    return w;
  endfunction

  task automatic fill(input bit allow_halt);
    for (int i = 0; i < 128; i++) mem[i] = rnd_inst(allow_halt);
  endtask

  task automatic step(input bit r, input bit s, input bit rd, input logic [8:0] rpc);
    logic [31:0] w;
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    chk("imem_addr_pre", {23'd0, imem_addr}, m_pc);
    w = mem[m_pc / 4];
    if (r) begin
      m_pc = 0; m_ipc = 0; m_ins = NOP; m_v = 0; m_h = 0;
    end else if (rd) begin
      m_ipc = m_pc; m_ins = NOP; m_v = 0; m_h = 0; m_pc = (int'(rpc) / 4) * 4;
    end else if (m_h) begin
      if (!s) begin m_ipc = m_pc; m_ins = NOP; m_v = 0; end
    end else if (!s) begin
      m_ipc = m_pc; m_ins = w; m_v = 1;
      if (w[6:0] == HALT) m_h = 1;
      else m_pc = (m_pc + 4) % 512;
    end
    @(posedge clk); #1;
    chk("imem_addr", {23'd0, imem_addr}, m_pc);
    chk("id_pc", {23'd0, id_pc}, m_ipc);
    chk("id_instr", id_instr, m_ins);
    chk("id_opcode", {25'd0, id_opcode}, {25'd0, m_ins[6:0]});
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_v});
    chk("halted", {31'd0, halted}, {31'd0, m_h});
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 9'd0);
  endtask

  initial begin
    fill(0);
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0;
    @(posedge clk); #1;
    m_pc = 0; m_ipc = 0; m_ins = NOP; m_v = 0; m_h = 0;
    step(1, 1, 1, 9'h55);
    chk("reset_instr", id_instr, NOP);
    // straight-line fetch of I0..I3
    adv(4);
    chk("seq_pc", {23'd0, id_pc}, 32'd12);
    chk("seq_instr", id_instr, mem[3]);
    // stall holding PC 8
    step(1, 0, 0, 9'd0);
    adv(3);
    step(0, 1, 0, 9'd0);
    step(0, 1, 0, 9'd0);
    chk("stall_pc", {23'd0, id_pc}, 32'd8);
    chk("stall_addr", {23'd0, imem_addr}, 32'd12);
    adv(1);
    chk("resume_pc", {23'd0, id_pc}, 32'd12);
    // redirect wins over stall
    step(0, 1, 1, 9'h043);
    chk("redir_addr", {23'd0, imem_addr}, 32'h40);
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    adv(2);
    // HALT at byte address 16
    step(1, 0, 0, 9'd0);
    mem[4] = {rnd_inst(0) >> 7, HALT};
    adv(5);
    chk("halt_pc", {23'd0, id_pc}, 32'd16);
    chk("halt_valid", {31'd0, id_valid}, 32'd1);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    adv(2);
    step(0, 1, 0, 9'd0);
    adv(3);
    chk("halt_frozen", {23'd0, imem_addr}, 32'd16);
    chk("halt_bubble", {31'd0, id_valid}, 32'd0);
    // redirect releases the halt
    step(0, 0, 1, 9'h020);
    chk("unhalt", {31'd0, halted}, 32'd0);
    chk("unhalt_addr", {23'd0, imem_addr}, 32'h20);
    adv(3);
    // wrap from 0x1FC
    step(0, 0, 1, 9'h1FC);
    adv(1);
    chk("wrap_addr", {23'd0, imem_addr}, 32'd0);
    chk("wrap_pc", {23'd0, id_pc}, 32'h1FC);
    adv(2);
    // random traffic with sporadic HALTs
    fill(1);
    for (int i = 0; i < 500; i++)
      step($urandom_range(49) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0, 9'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_W, default 9: program-counter and instruction-memory byte-address width.
REQ-002 Parameter INST_W, default 32: instruction width.
REQ-003 Parameter NOP_INST, default 32'h00000013: bubble instruction (addi x0,x0,0).
REQ-004 Parameter HALT_OPC, default 7'b1001100: halt opcode recognised by the downstream decoder.
REQ-005 clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 stall  input  1: hazard hold request; freezes PC and IF/ID register.
REQ-008 redirect  input  1: taken branch/JAL/JALR from a later stage; flushes fetch.
REQ-009 redirect_pc  input  PC_W: target byte address for redirect.
REQ-010 imem_addr  output  PC_W: instruction-memory byte address, combinational read.
REQ-011 imem_rdata  input  INST_W: instruction at imem_addr, valid in the same cycle.
REQ-012 id_pc  output  PC_W: PC of the instruction held in IF/ID.
REQ-013 id_instr  output  INST_W: instruction held in IF/ID.
REQ-014 id_opcode  output  7: id_instr[6:0], fed to the decode controller.
REQ-015 id_valid  output  1: IF/ID holds a real instruction (0 = bubble).
REQ-016 halted  output  1: a HALT has been fetched; fetch is frozen.

Function
REQ-017 imem_addr SHALL equal the PC register combinationally.
REQ-018 Per-cycle priority SHALL be reset > redirect > halted > stall > normal advance.
REQ-019 Normal advance: PC <= PC+4 modulo 2^PC_W; IF/ID <= {PC, imem_rdata, valid=1}.
REQ-020 Stall (no redirect, not halted): PC and the entire IF/ID register SHALL hold.
REQ-021 Redirect: PC <= {redirect_pc[PC_W-1:2],2'b00}; IF/ID <= {PC, NOP_INST, valid=0}; halted <= 0; applies even when stall or halted is 1.
REQ-022 HALT capture: on a normal advance with imem_rdata[6:0]==HALT_OPC, IF/ID SHALL capture the HALT with valid=1, PC SHALL hold, and halted SHALL be 1 from the next cycle.
REQ-023 While halted and no redirect: PC holds; if stall=0, IF/ID <= {PC, NOP_INST, valid=0} so the HALT drains downstream exactly once; if stall=1, IF/ID holds.
REQ-024 halted SHALL be sticky; it is cleared only by reset or redirect.
REQ-025 PC wrap: 2^PC_W-4 advances to 0 with no flag or exception.
REQ-026 id_opcode SHALL always equal id_instr[6:0], including bubbles (7'b0010011).
REQ-027 Fetch-to-decode latency SHALL be exactly one cycle; with no stall/redirect, one instruction per cycle.

Reset
REQ-028 While reset=1 at a clock edge: PC <= 0, id_pc <= 0, id_instr <= NOP_INST, id_valid <= 0, halted <= 0; stall and redirect are ignored.
REQ-029 First cycle after reset release: imem_addr=0; the instruction at address 0 reaches IF/ID on the following edge.
REQ-030 Reset asserted mid-stall, mid-redirect or while halted SHALL produce the state of REQ-028 at the next edge.

Verification
REQ-031 Reset, then 4 cycles with mem[0..12]=I0..I3 -> id_pc 0,4,8,12 with id_instr I0..I3, id_valid=1 each cycle.
REQ-032 stall=1 for 2 cycles while IF/ID holds PC 8 -> id_pc=8, imem_addr=12 held both cycles; resumes with id_pc=12.
REQ-033 redirect=1, redirect_pc=0x43, stall=1, same cycle -> next cycle imem_addr=0x40, id_valid=0, id_instr=0x00000013.
REQ-034 HALT (opcode 1001100) at address 16 -> id_pc=16 with the HALT valid, halted=1, then bubbles with imem_addr frozen at 16 indefinitely.
REQ-035 While halted, redirect to 0x20 -> halted=0, imem_addr=0x20, normal fetch resumes next cycle.
REQ-036 PC preloaded via redirect to 0x1FC (PC_W=9), then advance -> imem_addr wraps to 0x000, id_pc=0x1FC.
